uart_rx_oversampled: RTL

UART receiver that consumes the one-cycle oversampling tick from the baud-rate generator (its max_tick drives s_tick here). It deserialises an asynchronous rx line into DBIT-wide words, LSB first, with optional parity and stop-bit checking. It presents each word with a one-cycle done strobe to the downstream processing path. All logic runs on clk; s_tick is an enable, not a clock.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_oversampled.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry
// used by both the receiver and the future transmitter.
package uart_pkg;

  localparam int DBIT_DEF       = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SB_TICK_DEF    = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; the reset value
// lets an idle-high line come out of reset without a spurious edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: samples each bit at its centre using the
// baud-generator tick, with optional parity and stop/break detection.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int SB_TICK    = SB_TICK_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            busy
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);
  localparam logic          PAR_ON = (PARITY_EN != 0);

  state_t          state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            p_err, p_err_next;
  logic            stop_lvl, stop_lvl_next;
  logic [DBIT-1:0] dout_next;
  logic            parity_err_next, frame_err_next, done_next;
  logic            rx_s;
  logic            stop_now;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // With SB_TICK == OVERSAMPLE the stop-level capture and the frame end share a tick.
  assign stop_now = (s == S_BIT) ? rx_s : stop_lvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s            <= '0;
      n            <= '0;
      b            <= '0;
      p_err        <= 1'b0;
      stop_lvl     <= 1'b1;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      s            <= s_next;
      n            <= n_next;
      b            <= b_next;
      p_err        <= p_err_next;
      stop_lvl     <= stop_lvl_next;
      dout         <= dout_next;
      parity_err   <= parity_err_next;
      frame_err    <= frame_err_next;
      rx_done_tick <= done_next;
    end
  end

  always_comb begin
    state_next      = state;
    s_next          = s;
    n_next          = n;
    b_next          = b;
    p_err_next      = p_err;
    stop_lvl_next   = stop_lvl;
    dout_next       = dout;
    parity_err_next = parity_err;
    frame_err_next  = frame_err;
    done_next       = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_HALF) begin
            s_next = '0;
            n_next = '0;
            if (!rx_s) state_next = DATA;
            else       state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_next = '0;
            b_next = {rx_s, b[DBIT-1:1]};
            if (n == N_LAST) begin
              if (PAR_ON) state_next = PARITY;
              else        state_next = STOP;
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            p_err_next = (^b) ^ rx_s ^ ODD;
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_BIT) stop_lvl_next = rx_s;
          if (s == S_STOP) begin
            s_next          = '0;
            dout_next       = b;
            parity_err_next = PAR_ON & p_err;
            frame_err_next  = ~stop_now;
            done_next       = 1'b1;
            if (stop_now) state_next = IDLE;
            else          state_next = BRK_WAIT;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      BRK_WAIT: begin
        // Swallow a held-low line so a break reports a single framing error.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule
